// File: rtl/ext_slot_wait_ctrl_pkg.sv
// Shared types and helpers for the expanded-slot wait-state scheduler.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ext_slot_pkg;

  // Default I/O port of the wait-configuration register (A[7:0]).
  localparam logic [7:0] CFG_PORT_DEFAULT = 8'h4E;

  // Width of one per-sub-slot wait field; four fields pack into one byte.
  localparam int WAIT_W = 2;

  // Number of sub-slots behind the expander.
  localparam int NUM_SUB = 4;

  // Scheduler states. The 2-bit encoding leaves one unused value,
  // which the FSM treats as a return path to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Lowest-index active (low) sub-slot select. When no select is low
  // the result is 0, but callers only use it while an access is active.
  function automatic logic [1:0] lowest_sub(input logic [NUM_SUB-1:0] sel_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_SUB - 1; i >= 0; i--) begin
      if (!sel_n[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ext_slot_wait_ctrl_if.sv
// Slot bus bundle seen by the wait-state scheduler (everything except clock, reset and data).
// Latency: n/a (signal bundle only).
// Backpressure: SLT_WAITn is the only stall path, driven by the slave side.
interface ext_slot_wait_ctrl_if;

  logic        SLT_SLTSL;
  logic        SLT_MERQn;
  logic        SLT_IORQn;
  logic        SLT_RDn;
  logic        SLT_WEn;
  logic [15:0] SLT_A;
  logic [3:0]  EXTSLT_SELn;
  logic        SLT_WAITn;
  logic        WAIT_ACTIVE;

  // CPU / bus side: drives the cycle, observes the wait request.
  modport master (
    output SLT_SLTSL,
    output SLT_MERQn,
    output SLT_IORQn,
    output SLT_RDn,
    output SLT_WEn,
    output SLT_A,
    output EXTSLT_SELn,
    input  SLT_WAITn,
    input  WAIT_ACTIVE
  );

  // Scheduler side: observes the cycle, drives the wait request.
  modport slave (
    input  SLT_SLTSL,
    input  SLT_MERQn,
    input  SLT_IORQn,
    input  SLT_RDn,
    input  SLT_WEn,
    input  SLT_A,
    input  EXTSLT_SELn,
    output SLT_WAITn,
    output WAIT_ACTIVE
  );

endinterface

// File: rtl/ext_slot_cfg_reg.sv
// Wait-configuration register: decodes OUT to CFG_PORT and holds the packed per-sub-slot wait fields.
// Latency: cfg updates on the rising edge that samples the I/O write; readback drive is combinational.
// Backpressure: none; I/O cycles are never stretched. Optional readback: EXT_SLOT_CFG_READBACK_EN.
module ext_slot_cfg_reg
  import ext_slot_pkg::*;
#(
  parameter logic [7:0] CFG_PORT  = CFG_PORT_DEFAULT,
  parameter logic [7:0] CFG_RESET = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       iorq_n_i,
  input  logic       rd_n_i,
  input  logic       we_n_i,
  input  logic [7:0] addr_lo_i,
  inout  wire  [7:0] slt_d_io,
  output logic [7:0] cfg_o
);

  logic [7:0] cfg_q;
  logic [7:0] cfg_d;
  logic       wr_hit;

  // Only the low address byte decodes the port; the upper byte carries
  // the accumulator on OUT (n),A and is deliberately ignored.
  assign wr_hit = !iorq_n_i && !we_n_i && (addr_lo_i == CFG_PORT);

  // Next value of the configuration register.
  always_comb begin
    cfg_d = cfg_q;
    if (wr_hit) begin
      cfg_d = slt_d_io;
    end
  end

  // Configuration register with asynchronous reset to CFG_RESET.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= CFG_RESET;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  assign cfg_o = cfg_q;

`ifdef EXT_SLOT_CFG_READBACK_EN
  logic rd_hit;

  assign rd_hit = !iorq_n_i && !rd_n_i && (addr_lo_i == CFG_PORT);

  // Open-drain readback: zeros are pulled low, ones are left to the
  // bus pull-ups, and the bus is released as soon as the IN cycle ends.
  for (genvar b = 0; b < 8; b++) begin : g_rb
    assign slt_d_io[b] = (rd_hit && !cfg_q[b]) ? 1'b0 : 1'bz;
  end
`else
  // Without readback the data bus is input-only; RD is not needed.
  logic unused_rd_n;
  assign unused_rd_n = rd_n_i;
`endif

endmodule

// File: rtl/ext_slot_wait_ctrl.sv
// Per-sub-slot wait-state scheduler for the 4-way expanded slot (optional cfg readback: EXT_SLOT_CFG_READBACK_EN).
// Latency: SLT_WAITn falls one edge after the access is seen and stays low for the latched count n.
// Backpressure: stretches memory cycles via SLT_WAITn; an access dropping mid-wait releases it next edge.
module ext_slot_wait_ctrl #(
  parameter logic [7:0] CFG_PORT  = ext_slot_pkg::CFG_PORT_DEFAULT,
  parameter logic [7:0] CFG_RESET = 8'h00,
  parameter int         WAIT_W    = ext_slot_pkg::WAIT_W
) (
  input  logic                 SLT_CLOCK,
  input  logic                 SLT_RESETn,
  ext_slot_wait_ctrl_if.slave  bus,
  inout  wire  [7:0]           SLT_D
);

  import ext_slot_pkg::*;

  logic [7:0]        cfg;
  logic              acc;
  logic [1:0]        sub;
  logic [WAIT_W-1:0] n_sel;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              waitn_q, waitn_d;

  // The upper address byte plays no part in this block.
  logic [7:0] unused_a_hi;
  assign unused_a_hi = bus.SLT_A[15:8];

  ext_slot_cfg_reg #(
    .CFG_PORT  (CFG_PORT),
    .CFG_RESET (CFG_RESET)
  ) u_cfg (
    .clk_i     (SLT_CLOCK),
    .rst_ni    (SLT_RESETn),
    .iorq_n_i  (bus.SLT_IORQn),
    .rd_n_i    (bus.SLT_RDn),
    .we_n_i    (bus.SLT_WEn),
    .addr_lo_i (bus.SLT_A[7:0]),
    .slt_d_io  (SLT_D),
    .cfg_o     (cfg)
  );

  // A memory cycle into one of the sub-slots. FFFFh (the sub-slot
  // register) leaves every select high, so it never qualifies, and
  // IORQ cycles are excluded because MERQ stays high.
  assign acc = !bus.SLT_SLTSL && !bus.SLT_MERQn &&
               (!bus.SLT_RDn || !bus.SLT_WEn) && !(&bus.EXTSLT_SELn);

  // Lowest active select wins; its field supplies the wait count.
  assign sub   = lowest_sub(bus.EXTSLT_SELn);
  assign n_sel = cfg[int'(sub) * WAIT_W +: WAIT_W];

  // Next-state, counter and wait-request logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waitn_d = waitn_q;
    unique case (state_q)
      IDLE: begin
        waitn_d = 1'b1;
        if (acc) begin
          // Count is latched here; later cfg writes only affect the next access.
          cnt_d = n_sel;
          if (n_sel == '0) begin
            state_d = HOLD;
          end else begin
            state_d = WAIT;
            waitn_d = 1'b0;
          end
        end
      end
      WAIT: begin
        if (!acc) begin
          // Aborted access: release immediately and rearm.
          state_d = IDLE;
          waitn_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
          if (cnt_q == WAIT_W'(1)) begin
            state_d = HOLD;
            waitn_d = 1'b1;
          end
        end
      end
      HOLD: begin
        // Sit out the rest of this access so it cannot retrigger.
        waitn_d = 1'b1;
        if (!acc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        waitn_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered wait request; reset releases WAITn at once.
  always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
    if (!SLT_RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      waitn_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waitn_q <= waitn_d;
    end
  end

  assign bus.SLT_WAITn   = waitn_q;
  assign bus.WAIT_ACTIVE = (state_q == WAIT);

endmodule

// File: tb/tb_ext_slot_wait_ctrl.sv
// Scoreboard bench for ext_slot_wait_ctrl: directed test-plan cycles followed by random bus traffic.
// Each issued bus cycle pushes its expected wait-clock count; a monitor measures and pops.
// The reference model tracks cfg as a byte and predicts waits as min(field, access length).
module tb_ext_slot_wait_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ext_slot_wait_ctrl_if bus ();

  logic [7:0] tb_d;
  logic       tb_d_oe;
  wire  [7:0] slt_d;
  assign slt_d = tb_d_oe ? tb_d : 8'hzz;

  ext_slot_wait_ctrl #(
    .CFG_PORT  (8'h4E),
    .CFG_RESET (8'h00),
    .WAIT_W    (2)
  ) dut (
    .SLT_CLOCK  (clk),
    .SLT_RESETn (rst_n),
    .bus        (bus),
    .SLT_D      (slt_d)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int         exp_q[$];
  logic [7:0] cfg_m;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: wait count for a select pattern, from the model's cfg byte.
  function automatic int model_wait(input logic [3:0] sel_n, input int len);
    int n;
    n = 0;
    if (sel_n != 4'hF) begin
      for (int i = 3; i >= 0; i--) begin
        if (!sel_n[i]) n = (cfg_m >> (2 * i)) & 3;
      end
    end
    return (n < len) ? n : len;
  endfunction

  task automatic drive_idle();
    bus.SLT_SLTSL   = 1'b1;
    bus.SLT_MERQn   = 1'b1;
    bus.SLT_IORQn   = 1'b1;
    bus.SLT_RDn     = 1'b1;
    bus.SLT_WEn     = 1'b1;
    bus.SLT_A       = 16'h0000;
    bus.EXTSLT_SELn = 4'hF;
    tb_d            = 8'hFF;
    tb_d_oe         = 1'b1;
  endtask

  // Memory cycle held for len rising edges; optional OUT to the cfg port on its last edge.
  task automatic mem_access(input logic [3:0] sel_n, input logic [15:0] addr, input bit wr,
                            input int len, input bit mid_wr, input logic [7:0] mid_val);
    exp_q.push_back(model_wait(sel_n, len));
    if (mid_wr) cfg_m = mid_val;
    @(negedge clk);
    bus.SLT_SLTSL   = 1'b0;
    bus.SLT_MERQn   = 1'b0;
    bus.SLT_A       = addr;
    bus.EXTSLT_SELn = sel_n;
    if (wr) begin
      bus.SLT_WEn = 1'b0;
      tb_d = 8'($urandom);
    end else begin
      bus.SLT_RDn = 1'b0;
    end
    for (int i = 0; i < len; i++) begin
      if (mid_wr && i == len - 1) begin
        bus.SLT_IORQn  = 1'b0;
        bus.SLT_WEn    = 1'b0;
        bus.SLT_A[7:0] = 8'h4E;
        tb_d           = mid_val;
      end
      @(negedge clk);
    end
    drive_idle();
  endtask

  // I/O cycle; a read of the cfg port checks the data bus.
  task automatic io_cycle(input bit wr, input logic [15:0] addr, input logic [7:0] val, input int len);
    exp_q.push_back(0);
    if (wr && addr[7:0] == 8'h4E) cfg_m = val;
    @(negedge clk);
    bus.SLT_IORQn = 1'b0;
    bus.SLT_A     = addr;
    if (wr) begin
      bus.SLT_WEn = 1'b0;
      tb_d        = val;
    end else begin
      bus.SLT_RDn = 1'b0;
`ifdef EXT_SLOT_CFG_READBACK_EN
      if (addr[7:0] == 8'h4E) tb_d_oe = 1'b0;
`endif
    end
    repeat (len) @(negedge clk);
    if (!wr && addr[7:0] == 8'h4E) begin
`ifdef EXT_SLOT_CFG_READBACK_EN
      check("readback_zero_bits", 32'(slt_d & ~cfg_m), 32'd0);
`else
      check("readback_pullups", 32'(slt_d), 32'hFF);
`endif
    end
    drive_idle();
  endtask

  // Monitor: measures SLT_WAITn low clocks per bus cycle and scores them.
  initial begin : monitor
    bit in_win;
    int lows;
    bit cyc;
    in_win = 1'b0;
    lows   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        in_win = 1'b0;
        lows   = 0;
      end else begin
        cyc = ((!bus.SLT_SLTSL && !bus.SLT_MERQn) || !bus.SLT_IORQn) &&
              (!bus.SLT_RDn || !bus.SLT_WEn);
        check("wait_active_vs_waitn", 32'(bus.WAIT_ACTIVE), 32'(!bus.SLT_WAITn));
        if (!bus.SLT_WAITn) lows++;
        if (cyc) begin
          in_win = 1'b1;
        end else if (in_win) begin
          if (exp_q.size() == 0) check("scoreboard_underflow", 32'd1, 32'd0);
          else check("wait_clocks", 32'(lows), 32'(exp_q.pop_front()));
          in_win = 1'b0;
          lows   = 0;
        end else if (lows != 0) begin
          check("stray_wait", 32'(lows), 32'd0);
          lows = 0;
        end
      end
    end
  end

  initial begin : stim
    drive_idle();
    rst_n = 1'b0;
    cfg_m = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_waitn", 32'(bus.SLT_WAITn), 32'd1);
    check("reset_wait_active", 32'(bus.WAIT_ACTIVE), 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a 3-clock wait.
    io_cycle(1'b1, 16'h004E, 8'h03, 1);
    @(negedge clk);
    bus.SLT_SLTSL   = 1'b0;
    bus.SLT_MERQn   = 1'b0;
    bus.SLT_RDn     = 1'b0;
    bus.EXTSLT_SELn = 4'b1110;
    @(negedge clk);
    check("pre_reset_waitn", 32'(bus.SLT_WAITn), 32'd0);
    check("pre_reset_wait_active", 32'(bus.WAIT_ACTIVE), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait_waitn", 32'(bus.SLT_WAITn), 32'd1);
    check("reset_mid_wait_active", 32'(bus.WAIT_ACTIVE), 32'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    cfg_m = 8'h00;
    exp_q.delete();
    mon_en = 1'b1;

    // cfg back at reset value: no waits anywhere.
    mem_access(4'b1110, 16'h4000, 1'b0, 4, 1'b0, 8'h00);

    // Per-sub-slot stretch: sub0=3, sub1=2, sub2=1, sub3=0.
    io_cycle(1'b1, 16'h124E, 8'h1B, 1);
    mem_access(4'b1110, 16'h4000, 1'b0, 6, 1'b0, 8'h00);
    mem_access(4'b1101, 16'h4000, 1'b0, 6, 1'b0, 8'h00);
    mem_access(4'b1011, 16'h8000, 1'b1, 6, 1'b0, 8'h00);
    mem_access(4'b0111, 16'h8000, 1'b0, 6, 1'b0, 8'h00);

    // Abort after one wait clock, then a full-length retry.
    io_cycle(1'b1, 16'h004E, 8'h03, 2);
    mem_access(4'b1110, 16'h4000, 1'b0, 1, 1'b0, 8'h00);
    mem_access(4'b1110, 16'h4000, 1'b0, 5, 1'b0, 8'h00);

    // Exclusions: sub-slot register at FFFFh and I/O to 98h.
    io_cycle(1'b1, 16'h004E, 8'hFF, 1);
    mem_access(4'hF, 16'hFFFF, 1'b0, 4, 1'b0, 8'h00);
    mem_access(4'hF, 16'hFFFF, 1'b1, 4, 1'b0, 8'h00);
    io_cycle(1'b0, 16'h0098, 8'h00, 2);
    io_cycle(1'b1, 16'h0098, 8'h55, 2);

    // Priority (sub0 over sub1) and a cfg write during HOLD.
    io_cycle(1'b1, 16'h004E, 8'h0D, 1);
    mem_access(4'b1100, 16'h4000, 1'b0, 5, 1'b1, 8'h03);
    mem_access(4'b1100, 16'h4000, 1'b0, 5, 1'b0, 8'h00);

    // Readback of a written value.
    io_cycle(1'b1, 16'h774E, 8'hA5, 1);
    io_cycle(1'b0, 16'h884E, 8'h00, 2);

    // Random traffic.
    for (int it = 0; it < 200; it++) begin
      int          kind;
      logic [15:0] a;
      logic [3:0]  s;
      kind = int'($urandom_range(0, 9));
      a    = 16'($urandom);
      if (kind < 2) begin
        if ($urandom_range(0, 2) == 0) a[7:0] = 8'h4E;
        io_cycle(1'($urandom), a, 8'($urandom), int'($urandom_range(1, 3)));
      end else begin
        s = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        mem_access(s, a, 1'($urandom), int'($urandom_range(1, 5)),
                   ($urandom_range(0, 6) == 0), 8'($urandom));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ext_slot_wait_ctrl.md
Name: ext_slot_wait_ctrl

Overview:
- Per-sub-slot wait-state scheduler for the 4-way expanded slot.
- Watches slot memory cycles and the active-low sub-slot selects produced by the expansion decoder, then stretches each access by a programmable number of SLT_CLOCK cycles by pulling SLT_WAITn.
- Wait counts live in an I/O-mapped configuration register, so slow cartridges (ROM, SRAM, FM) can share the expander with fast ones.

Parameters:
- CFG_PORT, 8'h4E, I/O port address (A[7:0]) of the wait-configuration register.
- CFG_RESET, 8'h00, configuration value loaded on reset (all sub-slots zero wait).
- WAIT_W, 2, width of each per-sub-slot wait field (0..3 extra cycles).

Ports:
- SLT_CLOCK  in  1  slot clock, 3.58 MHz; all state on the rising edge.
- SLT_RESETn  in  1  reset.
- SLT_SLTSL  in  1  primary slot select, active low.
- SLT_MERQn  in  1  memory request, active low.
- SLT_IORQn  in  1  I/O request, active low.
- SLT_RDn  in  1  read strobe, active low.
- SLT_WEn  in  1  write strobe, active low.
- SLT_A  in  16  address bus.
- SLT_D  inout  8  data bus; input only unless readback is compiled in.
- EXTSLT_SELn  in  4  sub-slot selects from the expansion decoder, active low.
- SLT_WAITn  out  1  wait request, active low; 1 = released (top level converts to open-drain).
- WAIT_ACTIVE  out  1  debug flag, high while in the WAIT state.

Behaviour:
- Reset: SLT_RESETn is asynchronous, active-low.
  - cfg <= CFG_RESET, FSM <= IDLE, counter <= 0.
  - SLT_WAITn = 1 and WAIT_ACTIVE = 0 immediately, including mid-WAIT.
- Access active (acc): SLT_SLTSL=0 & SLT_MERQn=0 & (SLT_RDn=0 | SLT_WEn=0) & any EXTSLT_SELn bit = 0.
- Sub-slot pick: when more than one select is low, the lowest index wins. Its field is n = cfg[2i+1:2i].
- IDLE:
  - On a rising edge with acc=1, latch n into the counter.
  - n=0: go to HOLD; SLT_WAITn stays 1.
  - n>0: go to WAIT; SLT_WAITn <= 0.
- WAIT:
  - Counter decrements each edge.
  - When the counter equals 1 at an edge: SLT_WAITn <= 1, go to HOLD.
  - SLT_WAITn is low for exactly n rising edges, with first assertion registered one edge after acc is detected.
  - If acc drops during WAIT (abort): SLT_WAITn <= 1, go to IDLE.
- HOLD: stay until acc=0, then go to IDLE. This prevents a retrigger within one long access.
- Address FFFFh: all selects are high, so acc=0 and no wait is inserted. The sub-slot register access is never stretched.
- Config write:
  - Condition: SLT_IORQn=0 & SLT_WEn=0 & SLT_A[7:0]=CFG_PORT at a rising edge loads cfg <= SLT_D.
  - Upper address byte ignored.
- The count is latched at access start; a cfg write during WAIT or HOLD affects only the next access.
- IORQ cycles never trigger waits.
- Unused FSM encodings return to IDLE.

Optional Feature:
- Macro: EXT_SLOT_CFG_READBACK_EN.
- Defined: SLT_IORQn=0 & SLT_RDn=0 & SLT_A[7:0]=CFG_PORT drives cfg on SLT_D open-drain style (0 driven, 1 = high-Z); released combinationally when the condition drops.
- Undefined: SLT_D is never driven and reads of CFG_PORT return bus pull-ups (FFh).

Decomposition:
- Package ext_slot_pkg:
  - FSM state enum (IDLE, WAIT, HOLD).
  - CFG_PORT_DEFAULT and WAIT_W constants.
  - Function returning the lowest-index active sub-slot from EXTSLT_SELn.
- Sub-module ext_slot_cfg_reg: I/O decode, cfg register, optional readback driver.
- The FSM and counter stay in ext_slot_wait_ctrl.

Test Plan:
- Reset: assert SLT_RESETn=0 mid-WAIT -> SLT_WAITn=1 at once; cfg=00h; WAIT_ACTIVE=0.
- Config and stretch: OUT 4Eh,0x1B (sub0=3, sub1=2, sub2=1, sub3=0) -> memory read on sub0 holds SLT_WAITn low exactly 3 clocks; sub1 2 clocks; sub2 1 clock; sub3 0 clocks.
- Abort: cfg sub0=3, raise SLT_RDn after 1 wait clock -> SLT_WAITn=1 next edge; FSM in IDLE; next access waits a full 3 again.
- Exclusions: access FFFFh with cfg=FFh, plus an IORQ read/write to port 98h -> SLT_WAITn never low.
- Priority and mid-access write: EXTSLT_SELn=1100b with sub0=1, sub1=3 -> 1 wait clock. Write cfg during HOLD -> current access unaffected, next uses the new value.
- Readback: with EXT_SLOT_CFG_READBACK_EN, IN 4Eh after OUT 4Eh,0xA5 -> SLT_D=A5h. Without it -> SLT_D high-Z (FFh).
